// File: rtl/calc_pkg.sv
// Shared encodings for the calculator ALU sequencer:
// op codes, response error codes and FSM states.
package calc_pkg;

  localparam logic [3:0] OP_STOP = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0001;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RECOVER,
    S_RESP
  } state_t;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
  endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// WAIT-cycle watchdog: counts enabled cycles after a clear
// and flags expiry on the TIMEOUT-th one.
module seq_timeout_ctr #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // saturating cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (en && !expired)
      cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/alu_sequencer.sv
// Request/response front end for the calculator ALU:
// issues one op, rides out busy, parks the ALU, returns result.
module alu_sequencer
  import calc_pkg::*;
#(
  parameter int TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic       req_sign,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_err,
  output logic       alu_rst,
  output logic [3:0] alu_op,
  output logic       alu_sign,
  output logic [3:0] alu_data1,
  output logic [3:0] alu_data2,
  input  logic [7:0] alu_o,
  input  logic       alu_busy
);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cmd;
  logic       seen_busy;
  logic       rec_q;
  logic       expired;

  logic accept;
  logic addsub;
  logic done;
  logic in_wait;

  assign accept  = req_valid && req_ready;
  assign addsub  = (cmd == OP_ADD) || (cmd == OP_SUB);
  assign done    = seen_busy && !alu_busy;
  assign in_wait = (state == S_WAIT);

  seq_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == S_ISSUE),
    .en     (in_wait),
    .expired(expired)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // next-state; completion outranks a same-cycle timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (accept)
          state_nxt = is_onehot(req_op) ? S_ISSUE : S_RESP;
      S_ISSUE:
        state_nxt = S_WAIT;
      S_WAIT:
        if (addsub || done)
          state_nxt = S_RESP;
        else if (expired)
          state_nxt = S_RECOVER;
      S_RECOVER:
        if (rec_q)
          state_nxt = S_RESP;
      S_RESP:
        if (rsp_ready)
          state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // STOP must hit the ALU in the very cycle busy falls
  always_comb begin
    alu_op = OP_STOP;
    unique case (state)
      S_ISSUE: alu_op = cmd;
      S_WAIT:
        if (!addsub && !done)
          alu_op = cmd;
      default: alu_op = OP_STOP;
    endcase
  end

  // registered handshake flags and ALU reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      alu_rst   <= 1'b1;
    end else begin
      req_ready <= (state_nxt == S_IDLE);
      rsp_valid <= (state_nxt == S_RESP);
      alu_rst   <= (state_nxt == S_RECOVER);
    end
  end

  // operand latch, busy tracking, recover pacing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd       <= OP_STOP;
      alu_sign  <= 1'b0;
      alu_data1 <= 4'h0;
      alu_data2 <= 4'h0;
      seen_busy <= 1'b0;
      rec_q     <= 1'b0;
    end else begin
      if (accept) begin
        cmd       <= req_op;
        alu_sign  <= req_sign;
        alu_data1 <= req_a;
        alu_data2 <= req_b;
      end
      if (state == S_ISSUE)
        seen_busy <= 1'b0;
      else if (in_wait && alu_busy)
        seen_busy <= 1'b1;
      rec_q <= (state == S_RECOVER) && !rec_q;
    end
  end

  // response capture; o[7:5] is stale after ADD/SUB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= 8'h00;
      rsp_err  <= ERR_OK;
    end else begin
      unique case (1'b1)
        accept && !is_onehot(req_op): begin
          rsp_data <= 8'h00;
          rsp_err  <= ERR_ILLEGAL;
        end
        in_wait && addsub: begin
          rsp_data <= {3'b000, alu_o[4:0]};
          rsp_err  <= ERR_OK;
        end
        in_wait && !addsub && done: begin
          if (cmd == OP_DIV && alu_data2 == 4'h0) begin
            rsp_data <= 8'h00;
            rsp_err  <= ERR_DIV0;
          end else begin
            rsp_data <= alu_o;
            rsp_err  <= ERR_OK;
          end
        end
        in_wait && !addsub && !done && expired: begin
          rsp_data <= 8'h00;
          rsp_err  <= ERR_TIMEOUT;
        end
        default: begin
          rsp_data <= rsp_data;
          rsp_err  <= rsp_err;
        end
      endcase
    end
  end

endmodule
